regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (regwrite/waddr/wdata) between NREQ writeback requesters, e.g. ALU result, load return and CSR read.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered drive of the write port; writes to x0 are suppressed.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width
DW, 32, register data width
CW, 16, width of the issued-write counter

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
wb_stall  input  1  pipeline stall; blocks all grants while high
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*AW  per-requester destination register; requester i uses bits [i*AW +: AW]
req_data  input  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
req_ready  output  NREQ  per-requester grant, combinational, at most one bit high
regwrite  output  1  register-file write enable, registered
waddr  output  AW  register-file write address, registered
wdata  output  DW  register-file write data, registered
grant_id  output  $clog2(NREQ)  index of the last accepted requester, registered
wr_count  output  CW  number of writes issued to the register file

Behaviour:
- Clock and reset:
  - Single clock clk.
  - resetn is synchronous and active-low, sampled on the rising edge of clk, and has priority over all other inputs.
- Reset values: regwrite=0, waddr=0, wdata=0, grant_id=0, wr_count=0, rr_ptr=0.
- A request presented in a reset cycle is not accepted.
- Arbitration (combinational, within one cycle):
  - Search requesters starting at rr_ptr, ascending modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - If wb_stall=1 or resetn=0, all of req_ready is 0.
  - req_ready must not depend on the requester's own ready-to-valid path (no combinational loop).
- Handshake:
  - A transfer occurs on an edge where req_valid[i]=1 and req_ready[i]=1.
  - The requester holds valid, addr and data stable until it sees ready.
  - valid may deassert only after the transfer.
- Issue (latency of 1 cycle):
  - On the edge after transfer of requester i: waddr=req_addr_i, wdata=req_data_i, grant_id=i.
  - regwrite=1 if req_addr_i!=0; otherwise regwrite=0.
  - A write to x0 is consumed (ready given) but never reaches the register file.
  - If there is no transfer, regwrite=0 in the next cycle; waddr, wdata and grant_id hold their previous values.
- Round-robin pointer:
  - After a transfer from i, rr_ptr <= (i+1) mod NREQ.
  - With no transfer, rr_ptr is unchanged.
  - A continuously requesting set is served in rotating order; no requester waits more than NREQ-1 transfers.
- Counter: wr_count increments by 1 on every edge where the registered regwrite becomes 1 (x0 writes excluded). It wraps from 2^CW-1 to 0.
- Throughput: one transfer per cycle; back-to-back grants are allowed to the same or different requesters.
- Stall:
  - wb_stall=1 blocks new transfers.
  - A write already registered before the stall still completes (regwrite is high for its one cycle).
- Reset mid-operation: a pending registered write is dropped (regwrite forced to 0 on the reset edge) and rr_ptr returns to 0.
- Widths: NREQ not a power of two is supported. The rr_ptr wrap is explicit (NREQ-1 -> 0), not by truncation.

Test Plan:
- Reset, then requester 0 alone: addr=1, data=32'hAAAA_AAAA for one cycle -> req_ready[0]=1 that cycle; next cycle regwrite=1, waddr=1, wdata=AAAA_AAAA, grant_id=0; wr_count=1.
- All three requesters valid continuously: addr 2/3/4, data 32'h5555_5555/32'h1111_1111/32'h2222_2222 -> grants 0,1,2,0,1,2 on consecutive cycles; waddr sequence 2,3,4,2,3,4 one cycle later; exactly one req_ready bit high per cycle.
- Requester 1 writes addr=0, data=32'hDEAD_BEEF -> req_ready[1]=1; next cycle regwrite=0; wr_count unchanged; rr_ptr advances to 2.
- wb_stall=1 for 3 cycles with requesters 0 and 2 valid -> req_ready=0 for 3 cycles, regwrite=0; after release requester 0 is granted first (rr_ptr=0), then 2.
- Transfer on cycle N, then resetn=0 on cycle N+1 -> regwrite=0 and wr_count=0 after the reset edge; first grant after reset goes to the lowest valid index.
- CW=4 with 17 non-x0 writes -> wr_count reads 15 after the 15th write, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus and register-file write port shared by the requesters and the arbiter.
// The master side is the set of requesters; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               regwrite;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic [IW-1:0]      grant_id;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, regwrite, waddr, wdata, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, regwrite, waddr, wdata, grant_id
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between NREQ writeback
// sources; the winning request is registered onto the write port one cycle later.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wb_stall,
  regfile_wb_arbiter_if.slave     wb,
  output logic [CW-1:0]           wr_count
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = IW + 1;
  localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);

  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   wr_count_q, wr_count_d;

  logic            found;
  logic            xfer;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   sum;
  logic [NREQ-1:0] gnt_oh;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Search from rr_ptr upward, wrapping explicitly at NREQ so non-power-of-two counts work.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SW'(k);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = sum[IW-1:0];
      if (!found && wb.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Ready depends only on valid, stall, reset and the pointer: no path from ready back to valid.
  assign xfer = found && !wb_stall && resetn;

  always_comb begin
    gnt_oh = '0;
    if (xfer) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_addr = wb.req_addr[i*AW +: AW];
        sel_data = wb.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    grant_id_d = grant_id_q;
    if (xfer) begin
      waddr_d    = sel_addr;
      wdata_d    = sel_data;
      grant_id_d = gnt_idx;
      // x0 writes are consumed but never reach the register file.
      regwrite_d = (sel_addr != '0);
      rr_ptr_d   = (gnt_idx == LastIdx) ? '0 : gnt_idx + IW'(1);
    end
    wr_count_d = wr_count_q + CW'(regwrite_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q   <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wb.req_ready = gnt_oh;
  assign wb.regwrite  = regwrite_q;
  assign wb.waddr     = waddr_q;
  assign wb.wdata     = wdata_q;
  assign wb.grant_id  = grant_id_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, CW=4 so the counter wrap is reachable quickly).
module tb_regfile_wb_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;

  logic          clk;
  logic          resetn;
  logic          wb_stall;
  logic [CW-1:0] wr_count;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb ();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wb_stall (wb_stall),
    .wb       (wb),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and registered outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_g [6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    resetn       = 1'b0;
    wb_stall     = 1'b0;
    wb.req_valid = '0;
    wb.req_addr  = '0;
    wb.req_data  = '0;

    // Request presented during reset must not be accepted.
    wb.req_valid = 3'b001;
    wb.req_addr  = {5'd0, 5'd0, 5'd7};
    wb.req_data  = {32'd0, 32'd0, 32'h0BAD_0BAD};
    #1;
    chk("rst_ready", wb.req_ready, 3'b000);
    tick();
    tick();
    chk("rst_regwrite", wb.regwrite, 1'b0);
    chk("rst_waddr", wb.waddr, 5'd0);
    chk("rst_wdata", wb.wdata, 32'd0);
    chk("rst_grant_id", wb.grant_id, 2'd0);
    chk("rst_wr_count", wr_count, 4'd0);

    // Single request from requester 0.
    resetn       = 1'b1;
    wb.req_valid = 3'b001;
    wb.req_addr  = {5'd0, 5'd0, 5'd1};
    wb.req_data  = {32'd0, 32'd0, 32'hAAAA_AAAA};
    #1;
    chk("single_ready", wb.req_ready, 3'b001);
    tick();
    wb.req_valid = '0;
    chk("single_regwrite", wb.regwrite, 1'b1);
    chk("single_waddr", wb.waddr, 5'd1);
    chk("single_wdata", wb.wdata, 32'hAAAA_AAAA);
    chk("single_grant_id", wb.grant_id, 2'd0);
    chk("single_wr_count", wr_count, 4'd1);

    // All requesters continuously valid; pointer starts at 1 after the previous grant.
    wb.req_valid = 3'b111;
    wb.req_addr  = {5'd4, 5'd3, 5'd2};
    wb.req_data  = {32'h2222_2222, 32'h1111_1111, 32'h5555_5555};
    for (int c = 0; c < 6; c++) begin
      #0;
      chk("rr_ready", wb.req_ready, 64'(1) << exp_g[c]);
      tick();
      chk("rr_waddr", wb.waddr, 64'(2 + exp_g[c]));
      chk("rr_grant_id", wb.grant_id, 64'(exp_g[c]));
      chk("rr_regwrite", wb.regwrite, 1'b1);
    end
    wb.req_valid = '0;
    chk("rr_wr_count", wr_count, 4'd7);
    tick();
    chk("idle_regwrite", wb.regwrite, 1'b0);
    chk("idle_waddr_hold", wb.waddr, 5'd2);
    chk("idle_grant_hold", wb.grant_id, 2'd0);
    chk("idle_wr_count", wr_count, 4'd7);

    // Write to x0 from requester 1: consumed, not issued.
    wb.req_valid = 3'b010;
    wb.req_addr  = {5'd4, 5'd0, 5'd2};
    wb.req_data  = {32'h2222_2222, 32'hDEAD_BEEF, 32'h5555_5555};
    #1;
    chk("x0_ready", wb.req_ready, 3'b010);
    tick();
    wb.req_valid = '0;
    chk("x0_regwrite", wb.regwrite, 1'b0);
    chk("x0_wdata", wb.wdata, 32'hDEAD_BEEF);
    chk("x0_grant_id", wb.grant_id, 2'd1);
    chk("x0_wr_count", wr_count, 4'd7);

    // Pointer now 2: requester 2 wins over 0, then a stall holds off requester 0.
    wb.req_valid = 3'b101;
    #1;
    chk("ptr2_ready", wb.req_ready, 3'b100);
    tick();
    wb_stall = 1'b1;
    chk("prestall_regwrite", wb.regwrite, 1'b1);
    chk("prestall_waddr", wb.waddr, 5'd4);
    chk("prestall_grant_id", wb.grant_id, 2'd2);
    chk("prestall_wr_count", wr_count, 4'd8);
    for (int s = 0; s < 3; s++) begin
      #0;
      chk("stall_ready", wb.req_ready, 3'b000);
      tick();
      chk("stall_regwrite", wb.regwrite, 1'b0);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_ready0", wb.req_ready, 3'b001);
    tick();
    chk("unstall_grant0", wb.grant_id, 2'd0);
    chk("unstall_waddr0", wb.waddr, 5'd2);
    chk("unstall_wr_count0", wr_count, 4'd9);
    chk("unstall_ready2", wb.req_ready, 3'b100);
    tick();
    wb.req_valid = '0;
    chk("unstall_grant2", wb.grant_id, 2'd2);
    chk("unstall_wr_count2", wr_count, 4'd10);

    // Transfer, then reset the following cycle: the registered write is dropped.
    wb.req_valid = 3'b010;
    wb.req_addr  = {5'd4, 5'd9, 5'd2};
    wb.req_data  = {32'h2222_2222, 32'h0000_1234, 32'h5555_5555};
    #1;
    chk("prerst_ready", wb.req_ready, 3'b010);
    tick();
    chk("prerst_regwrite", wb.regwrite, 1'b1);
    chk("prerst_wr_count", wr_count, 4'd11);
    resetn       = 1'b0;
    wb.req_valid = 3'b101;
    #1;
    chk("midrst_ready", wb.req_ready, 3'b000);
    tick();
    chk("midrst_regwrite", wb.regwrite, 1'b0);
    chk("midrst_wr_count", wr_count, 4'd0);
    chk("midrst_waddr", wb.waddr, 5'd0);
    chk("midrst_grant_id", wb.grant_id, 2'd0);
    resetn = 1'b1;
    #1;
    chk("postrst_ready", wb.req_ready, 3'b001);
    tick();
    chk("postrst_grant_id", wb.grant_id, 2'd0);
    chk("postrst_wr_count", wr_count, 4'd1);

    // Counter wrap: writes 2..17 back-to-back from requester 0 alone.
    wb.req_valid = 3'b001;
    for (int i = 2; i <= 17; i++) begin
      tick();
      if (i == 15) chk("wrap_cnt15", wr_count, 4'd15);
      if (i == 16) chk("wrap_cnt16", wr_count, 4'd0);
      if (i == 17) chk("wrap_cnt17", wr_count, 4'd1);
    end
    wb.req_valid = '0;
    tick();
    chk("final_regwrite", wb.regwrite, 1'b0);
    chk("final_wr_count", wr_count, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
